lsu_mem_ctrl: RTL and testbench

- Load/store initiator between the CPU datapath and the 256×32 word-addressed data memory.
- The data memory samples WE/ADDR/WD on the falling clock edge and registers RD on that edge.
- Accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake.
- Drives the memory port, performs read-modify-write for sub-word stores, and returns extended load data or an error.

---
 rtl/lsu_mem_ctrl.sv | 150 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a word-addressed data memory that samples on the falling edge.
// Handles byte/half/word accesses, sub-word stores by read-modify-write, and rejects bad requests.
module lsu_mem_ctrl #(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;

  logic [1:0]  r_state;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic        r_err_pend;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wd;

  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  always_comb begin
    w_err = (req_size == 2'b11) ||
            (req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
            (|req_addr[31:MEM_AW+2]);

    w_byte = mem_rd[{r_lane, 3'b000} +: 8];
    w_half = mem_rd[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rd;
    endcase

    // Only the addressed lane is replaced; the rest comes from the read phase.
    w_merged = mem_rd;
    if (r_size == 2'b00) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      r_err_pend   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wd     <= 32'h0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_err_pend   <= 1'b0;
      // A rejected request answers one cycle after acceptance, like a load.
      if (r_err_pend) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b1;
        r_resp_rdata <= 32'h0;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_err) begin
              r_err_pend <= 1'b1;
            end else begin
              r_we       <= req_we;
              r_size     <= req_size;
              r_signed   <= req_signed;
              r_lane     <= req_addr[1:0];
              r_wdata    <= req_wdata[15:0];
              r_mem_addr <= {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
              if (req_we && req_size == 2'b10) begin
                r_mem_we <= 1'b1;
                r_mem_wd <= req_wdata;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_state <= S_IDLE;
          if (!r_we) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
          end else if (r_size == 2'b10) begin
            r_mem_we     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'h0;
          end else begin
            r_mem_wd <= w_merged;
            r_mem_we <= 1'b1;
            r_state  <= S_RMW_WR;
          end
        end
        S_RMW_WR: begin
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= 32'h0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wd     = r_mem_wd;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: falling-edge memory, byte-array reference model, vector table,
// random traffic and hand-written back-to-back / reset-during-RMW sequences.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int checks = 0;
  int failures = 0;

  lsu_mem_ctrl #(.MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Data memory: samples on the falling edge and registers RD there.
  logic [31:0] mem [0:255];
  bit          mem_init_done = 1'b0;
  int          we_total = 0;
  logic [31:0] last_we_addr = 32'h0;
  logic [31:0] last_we_wd = 32'h0;

  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
      mem_rd <= 32'h0;
    end else begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wd;
        we_total     <= we_total + 1;
        last_we_addr <= mem_addr;
        last_we_wd   <= mem_wd;
      end
      mem_rd <= mem[mem_addr[7:0]];
    end
  end

  // Reference model: flat byte-addressed memory, little-endian.
  logic [7:0] ref_bytes [0:1023];

  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if ((addr % (32'd1 << size)) != 0) return 1'b1;
    return addr >= 32'd1024;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
    int nb;
    logic [31:0] v;
    nb = 1 << size;
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
    if (sgn && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] model_word(input int widx);
    return {ref_bytes[4*widx+3], ref_bytes[4*widx+2], ref_bytes[4*widx+1], ref_bytes[4*widx]};
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    for (int i = 0; i < (1 << size); i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic g_err, output logic [31:0] g_rdata, output int lat,
                        output int wecnt, output logic [31:0] g_waddr,
                        output logic [31:0] g_wwd);
    int n;
    int we0;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    we0 = we_total;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble request fields: they must be ignored after acceptance.
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 10);
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    g_err = resp_err;
    g_rdata = resp_rdata;
    wecnt = we_total - we0;
    g_waddr = last_we_addr;
    g_wwd = last_we_wd;
  endtask

  task automatic apply(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input logic [31:0] exp_wd);
    logic g_err;
    logic [31:0] g_rd, g_wa, g_wd;
    int lat, wec, exp_lat;
    do_req(we, size, sgn, addr, wdata, g_err, g_rd, lat, wec, g_wa, g_wd);
    exp_lat = (!exp_err && we && size < 2) ? 2 : 1;
    check({tag, "_err"}, 32'(g_err), 32'(exp_err));
    check({tag, "_rdata"}, g_rd, exp_rdata);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_we_cycles"}, 32'(wec), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      check({tag, "_we_addr"}, g_wa, {22'h0, addr[9:2]});
      check({tag, "_wd"}, g_wd, exp_wd);
    end
    $display("TXN %s we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> err=%0d rdata=%h lat=%0d",
             tag, we, size, sgn, addr, wdata, g_err, g_rd, lat);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, wd, er, exd;
    logic [1:0] sz;
    logic w, sg, e;
    int ready_cnt, resp_cnt, coinc_bad, bad;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h11223344, 1'b0, 32'h0,        32'h11223344};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h11,  32'hFFFFFFA5, 1'b0, 32'h0,        32'h1122A544};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h1122A544, 32'h0};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h20,  32'h8081F0F0, 1'b0, 32'h0,        32'h8081F0F0};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h22,  32'h0,        1'b0, 32'hFFFFFF81, 32'h0};
    vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h22,  32'h0,        1'b0, 32'h00000081, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h20,  32'h0,        1'b0, 32'hFFFFF0F0, 32'h0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        1'b0, 32'h00008081, 32'h0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h13,  32'hCAFEF00D, 1'b1, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h05,  32'h0,        1'b1, 32'h0,        32'h0};
    vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h10,  32'h12345678, 1'b1, 32'h0,        32'h0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0,        32'h0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 32'h12,  32'h0000BEEF, 1'b0, 32'h0,        32'hBEEFA544};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'hBEEFA544, 32'h0};

    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = init_word(i) >> (8 * k);
    end

    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wd", mem_wd, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
            vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_wd);
      if (vecs[i].we && !model_err(vecs[i].size, vecs[i].addr))
        model_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
    end

    // Back-to-back loads with req_valid held high.
    repeat (2) @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid = 1'b1;
    ready_cnt = 0; resp_cnt = 0; coinc_bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (req_ready) ready_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (!req_ready) coinc_bad++;
        check("b2b_rdata", resp_rdata, model_word(4));
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_ready_cycles", 32'(ready_cnt), 32'd4);
    check("b2b_resp_count", 32'(resp_cnt), 32'd3);
    check("b2b_resp_with_ready", 32'(coinc_bad), 32'd0);
    $display("TXN b2b ready_cycles=%0d responses=%0d", ready_cnt, resp_cnt);
    repeat (2) @(negedge clk);

    // Reset asserted during the write cycle of a halfword RMW.
    req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h22; req_wdata = 32'h1357;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 check("rmw_we_before_rst", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_mem_we", 32'(mem_we), 32'd0);
    check("rst_async_ready", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_resp", 32'(resp_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    $display("TXN rst_mid_rmw addr=00000022");
    apply("rst_reload", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, model_word(8), 32'h0);

    for (int t = 0; t < 150; t++) begin
      w = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) a = a & ~32'(3);
      wd = $urandom;
      e = model_err(sz, a);
      er = (w || e) ? 32'h0 : model_load(sz, sg, a);
      exd = 32'h0;
      if (w && !e) begin
        model_store(sz, a, wd);
        exd = model_word(int'(a >> 2));
      end
      apply($sformatf("rnd%0d", t), w, sz, sg, a, wd, e, er, exd);
    end

    repeat (2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== model_word(i)) bad++;
    check("mem_image_bad_words", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
